ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/mem_arb_pkg.sv | 56 +++++
 rtl/load_extend.sv | 30 +++
 rtl/ram_arbiter.sv | 123 ++++++++++++
 tb/tb_ram_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master data RAM arbiter.
// Latency: n/a (package). Backpressure: n/a.
// Contents: FSM state enum, RV32I load/store width codes, command struct, legality check.
package mem_arb_pkg;

  localparam int MEM_WORDS_DEFAULT = 64;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Command latched from the winning master; master=1 means m1.
  typedef struct packed {
    logic        master;
    logic        we;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  // An access is legal when it is in range, naturally aligned for its width,
  // and uses a width code valid for its direction.
  function automatic logic access_legal(input logic        we,
                                        input logic [2:0]  func3,
                                        input logic [31:0] addr,
                                        input int unsigned mem_words);
    logic ok;
    ok = 1'b1;
    if ({2'b00, addr[31:2]} >= mem_words) ok = 1'b0;
    if (we) begin
      case (func3)
        F3_B:    ok = ok;
        F3_H:    if (addr[0]) ok = 1'b0;
        F3_W:    if (addr[1:0] != 2'b00) ok = 1'b0;
        default: ok = 1'b0;
      endcase
    end else begin
      case (func3)
        F3_B, F3_BU: ok = ok;
        F3_H, F3_HU: if (addr[0]) ok = 1'b0;
        F3_W:        if (addr[1:0] != 2'b00) ok = 1'b0;
        default:     ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Extracts the addressed byte/half/word from a RAM word and sign/zero-extends it.
// Latency: combinational. Backpressure: none.
// Ports: func3 (width code), addr_lo (byte offset), word (RAM word) -> data (extended result).
module load_extend
  import mem_arb_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b    = word[{addr_lo, 3'b000} +: 8];
    h    = addr_lo[1] ? word[31:16] : word[15:0];
    data = '0;
    case (func3)
      F3_B:    data = {{24{b[7]}}, b};
      F3_H:    data = {{16{h[15]}}, h};
      F3_W:    data = word;
      F3_BU:   data = {24'h0, b};
      F3_HU:   data = {16'h0, h};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter giving two masters (m0 CPU, m1 debug/DMA) access to one data RAM.
// Latency: req sampled at edge N -> ack in the cycle after edge N+2; one access per 3 cycles.
// Backpressure: masters hold req until ack; the loser simply waits in IDLE for the next slot.
// Ports: clk/reset_n; m0_*/m1_* request (req, we, func3, addr, wdata) and response
// (ack, err, rdata); ram_* command out (we, func3, addr, wdata) and ram_rdata in.
module ram_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [2:0]  m0_func3,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,

  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [2:0]  m1_func3,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,

  output logic        ram_we,
  output logic [2:0]  ram_func3,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  state_t      state;
  cmd_t        cmd;
  logic        last_m1;   // 1 when m1 held the most recent grant
  logic [31:0] cmd_word;  // RAM word captured at the end of ACCESS
  logic        grant_m1;
  logic        cmd_legal;
  logic        in_access;
  logic [31:0] ext_data;
  logic [31:0] resp_data;

  // m1 wins when alone, or on a tie when m0 was granted last.
  assign grant_m1  = m1_req && (!m0_req || !last_m1);
  assign cmd_legal = access_legal(cmd.we, cmd.func3, cmd.addr, int'(MEM_WORDS));
  assign in_access = (state == ST_ACCESS);

  // RAM command is decoded from state so reset removes the write strobe immediately.
  assign ram_we    = in_access && cmd.we && cmd_legal;
  assign ram_addr  = in_access ? cmd.addr  : '0;
  assign ram_func3 = in_access ? cmd.func3 : '0;
  assign ram_wdata = in_access ? cmd.wdata : '0;

  load_extend u_load_extend (
    .func3   (cmd.func3),
    .addr_lo (cmd.addr[1:0]),
    .word    (cmd_word),
    .data    (ext_data)
  );

  // Stores and illegal accesses return zero data.
  assign resp_data = (cmd_legal && !cmd.we) ? ext_data : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cmd      <= '0;
      last_m1  <= 1'b1;
      cmd_word <= '0;
      m0_ack   <= 1'b0;
      m0_err   <= 1'b0;
      m0_rdata <= '0;
      m1_ack   <= 1'b0;
      m1_err   <= 1'b0;
      m1_rdata <= '0;
    end else begin
      // Response outputs are single-cycle pulses.
      m0_ack   <= 1'b0;
      m0_err   <= 1'b0;
      m0_rdata <= '0;
      m1_ack   <= 1'b0;
      m1_err   <= 1'b0;
      m1_rdata <= '0;
      case (state)
        ST_IDLE: begin
          if (m0_req || m1_req) begin
            cmd.master <= grant_m1;
            cmd.we     <= grant_m1 ? m1_we    : m0_we;
            cmd.func3  <= grant_m1 ? m1_func3 : m0_func3;
            cmd.addr   <= grant_m1 ? m1_addr  : m0_addr;
            cmd.wdata  <= grant_m1 ? m1_wdata : m0_wdata;
            last_m1    <= grant_m1;
            state      <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          cmd_word <= ram_rdata;
          state    <= ST_RESP;
        end
        ST_RESP: begin
          if (cmd.master) begin
            m1_ack   <= 1'b1;
            m1_err   <= !cmd_legal;
            m1_rdata <= resp_data;
          end else begin
            m0_ack   <= 1'b1;
            m0_err   <= !cmd_legal;
            m0_rdata <= resp_data;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [2:0]  m0_func3, m1_func3;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_we;
  logic [2:0]  ram_func3;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int we_cnt   = 0;
  int we_base;

  typedef struct {
    int          master;
    logic        err;
    logic [31:0] rdata;
    int          ack_cyc;
  } exp_t;
  exp_t sb[$];

  logic [31:0] mem [0:63];

  ram_arbiter #(.MEM_WORDS(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_func3(m0_func3), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_func3(m1_func3), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .ram_we(ram_we), .ram_func3(ram_func3), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: combinational read, byte-lane write of LSB-aligned data.
  assign ram_rdata = (ram_addr[31:8] == 24'h0) ? mem[ram_addr[7:2]] : 32'h0;
  always @(posedge clk) begin
    if (ram_we) begin
      case (ram_func3[1:0])
        2'b00:   mem[ram_addr[7:2]][{ram_addr[1:0], 3'b000} +: 8] <= ram_wdata[7:0];
        2'b01:   mem[ram_addr[7:2]][{ram_addr[1], 4'b0000} +: 16] <= ram_wdata[15:0];
        default: mem[ram_addr[7:2]] <= ram_wdata;
      endcase
    end
  end

  always @(negedge clk) if (ram_we === 1'b1) we_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ack is matched against the next scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (m0_ack === 1'b1 || m1_ack === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack m0_ack=%b m1_ack=%b expected=none (cyc %0d)", m0_ack, m1_ack, cyc);
      end else begin
        e = sb.pop_front();
        chk("ack_master", {31'h0, m1_ack}, e.master);
        chk("ack_cycle", cyc, e.ack_cyc);
        if (e.master == 0) begin
          chk("m0_err", {31'h0, m0_err}, {31'h0, e.err});
          chk("m0_rdata", m0_rdata, e.rdata);
          chk("m1_idle_outputs", {m1_ack, m1_err, m1_rdata[29:0]}, 32'h0);
        end else begin
          chk("m1_err", {31'h0, m1_err}, {31'h0, e.err});
          chk("m1_rdata", m1_rdata, e.rdata);
          chk("m0_idle_outputs", {m0_ack, m0_err, m0_rdata[29:0]}, 32'h0);
        end
      end
    end
  end

  task automatic expect_ack(input int m, input logic err, input logic [31:0] rd, input int off);
    exp_t e;
    e.master  = m;
    e.err     = err;
    e.rdata   = rd;
    e.ack_cyc = cyc + off;
    sb.push_back(e);
  endtask

  task automatic set_req(input int m, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
    if (m == 0) begin
      m0_we = we; m0_func3 = f3; m0_addr = a; m0_wdata = wd; m0_req = 1'b1;
    end else begin
      m1_we = we; m1_func3 = f3; m1_addr = a; m1_wdata = wd; m1_req = 1'b1;
    end
  endtask

  task automatic drop_req(input int m);
    if (m == 0) m0_req = 1'b0;
    else        m1_req = 1'b0;
  endtask

  // Holds req for n consecutive acks (bounded wait for each), then releases it.
  task automatic hold(input int m, input int n, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd);
    int  t;
    bit  got;
    set_req(m, we, f3, a, wd);
    for (int i = 0; i < n; i++) begin
      t   = 0;
      got = 1'b0;
      while (!got && t < 20) begin
        @(negedge clk);
        t++;
        if ((m == 0) ? m0_ack : m1_ack) got = 1'b1;
      end
      if (!got) begin
        checks++;
        failures++;
        $display("FAIL ack_timeout master=%0d actual=no_ack required=ack", m);
      end
    end
    drop_req(m);
  endtask

  task automatic single(input int m, input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic err, input logic [31:0] rd);
    @(negedge clk);
    expect_ack(m, err, rd, 3);
    hold(m, 1, we, f3, a, wd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[1]  = 32'hA5A5A5A5;
    mem[63] = 32'h0BADF00D;
    reset_n = 1'b0;
    m0_req = 0; m0_we = 0; m0_func3 = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_func3 = 0; m1_addr = 0; m1_wdata = 0;

    // Reset state
    @(negedge clk);
    chk("rst_acks", {30'h0, m0_ack, m1_ack}, 32'h0);
    chk("rst_errs", {30'h0, m0_err, m1_err}, 32'h0);
    chk("rst_rdata", m0_rdata | m1_rdata, 32'h0);
    chk("rst_ram_cmd", {28'h0, ram_we, ram_func3} | ram_addr | ram_wdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Word store then load, sub-word stores and extending loads
    single(0, 1, F3_W,  32'h08, 32'hDEADBEEF, 0, 32'h0);
    chk("mem_w08", mem[2], 32'hDEADBEEF);
    single(0, 0, F3_W,  32'h08, 32'h0, 0, 32'hDEADBEEF);
    single(0, 1, F3_B,  32'h0D, 32'h12345680, 0, 32'h0);
    chk("mem_sb0d", mem[3], 32'h00008000);
    single(0, 0, F3_B,  32'h0D, 32'h0, 0, 32'hFFFFFF80);
    single(0, 0, F3_BU, 32'h0D, 32'h0, 0, 32'h00000080);
    single(1, 1, F3_H,  32'h0E, 32'hFFFFCAFE, 0, 32'h0);
    chk("mem_sh0e", mem[3], 32'hCAFE8000);
    single(1, 0, F3_HU, 32'h0E, 32'h0, 0, 32'h0000CAFE);
    single(1, 0, F3_H,  32'h0E, 32'h0, 0, 32'hFFFFCAFE);
    single(1, 0, F3_H,  32'h0C, 32'h0, 0, 32'hFFFF8000);
    single(0, 0, F3_B,  32'h0A, 32'h0, 0, 32'hFFFFFFAD);
    single(1, 0, F3_BU, 32'h0B, 32'h0, 0, 32'h000000DE);

    // Both masters held for two accesses each: strict alternation, 3 cycles apart
    @(negedge clk);
    expect_ack(0, 0, 32'hDEADBEEF, 3);
    expect_ack(1, 0, 32'hCAFE8000, 6);
    expect_ack(0, 0, 32'hDEADBEEF, 9);
    expect_ack(1, 0, 32'hCAFE8000, 12);
    fork
      hold(0, 2, 0, F3_W, 32'h08, 32'h0);
      hold(1, 2, 0, F3_W, 32'h0C, 32'h0);
    join

    // Illegal accesses and the last in-range word
    we_base = we_cnt;
    single(0, 1, F3_W,   32'h06,  32'h11111111, 1, 32'h0);
    single(0, 0, F3_W,   32'h100, 32'h0,        1, 32'h0);
    single(1, 1, F3_H,   32'h01,  32'h22222222, 1, 32'h0);
    single(1, 0, 3'b011, 32'h00,  32'h0,        1, 32'h0);
    single(0, 1, 3'b100, 32'h04,  32'h33333333, 1, 32'h0);
    single(1, 0, F3_H,   32'h0D,  32'h0,        1, 32'h0);
    single(0, 1, F3_B,   32'h100, 32'h44444444, 1, 32'h0);
    single(0, 0, F3_W,   32'hFC,  32'h0,        0, 32'h0BADF00D);
    chk("illegal_no_ram_we", we_cnt - we_base, 32'h0);
    chk("illegal_word1", mem[1], 32'hA5A5A5A5);
    chk("illegal_word0", mem[0], 32'h0);

    // Reset in the middle of a store
    @(negedge clk);
    set_req(0, 1, F3_W, 32'h04, 32'h12345678);
    @(negedge clk);
    chk("access_ram_we", {31'h0, ram_we}, 32'h1);
    chk("access_ram_addr", ram_addr, 32'h04);
    reset_n = 1'b0;
    #1;
    chk("reset_ram_we_drop", {31'h0, ram_we}, 32'h0);
    chk("reset_ram_addr", ram_addr, 32'h0);
    drop_req(0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_word1", mem[1], 32'hA5A5A5A5);

    // After reset the tie goes to m0 again
    @(negedge clk);
    expect_ack(0, 0, 32'hA5A5A5A5, 3);
    expect_ack(1, 0, 32'h00000080, 6);
    fork
      hold(0, 1, 0, F3_W,  32'h04, 32'h0);
      hold(1, 1, 0, F3_BU, 32'h0D, 32'h0);
    join

    // Request dropped early still completes
    @(negedge clk);
    expect_ack(0, 0, 32'hDEADBEEF, 3);
    set_req(0, 0, F3_W, 32'h08, 32'h0);
    @(negedge clk);
    drop_req(0);
    repeat (6) @(negedge clk);

    chk("scoreboard_drained", sb.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
